// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259 interrupt-acknowledge sequencer.
// The priority rank is a 3-bit wrap-around distance from the lowest-priority level.
package pic_pkg;

   localparam int NUM_IRQ = 8;
   localparam int IDX_W   = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACK1,
      ST_GAP,
      ST_ACK2
   } state_e;

   // Rank 0 is the level just above lowest_prio, so the 3-bit wrap does the modulo.
   function automatic logic [IDX_W-1:0] rank(input logic [IDX_W-1:0] idx,
                                             input logic [IDX_W-1:0] lowest);
      rank = idx - lowest - IDX_W'(1);
   endfunction

   function automatic logic [NUM_IRQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      onehot = NUM_IRQ'(1) << idx;
   endfunction

endpackage

// File: rtl/pic_inta_sequencer_if.sv
// CPU-side interrupt bus: INT request, INTA handshake and vector byte.
interface pic_inta_sequencer_if;

   logic       inta_n;
   logic       int_out;
   logic [7:0] vec_out;
   logic       vec_oe;

   modport master (
      output inta_n,
      input  int_out,
      input  vec_out,
      input  vec_oe
   );

   modport slave (
      input  inta_n,
      output int_out,
      output vec_out,
      output vec_oe
   );

endinterface

// File: rtl/pic_prio_resolver.sv
// Rotating priority encoder: returns the highest-ranked set bit of vec
// relative to the current lowest-priority level.
module pic_prio_resolver
   import pic_pkg::*;
(
   input  logic [NUM_IRQ-1:0] vec,
   input  logic [IDX_W-1:0]   lowest,
   output logic               found,
   output logic [IDX_W-1:0]   idx
);

   logic [IDX_W-1:0] best_rank;

   always_comb begin
      found     = 1'b0;
      idx       = '0;
      best_rank = '1;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (vec[i] && (!found || rank(IDX_W'(i), lowest) < best_rank)) begin
            found     = 1'b1;
            idx       = IDX_W'(i);
            best_rank = rank(IDX_W'(i), lowest);
         end
      end
   end

endmodule

// File: rtl/pic_inta_sequencer.sv
// 8259 core: priority resolution, INT generation, two-pulse INTA sequencing,
// vector drive, and EOI / AEOI / set-priority handling of the in-service register.
module pic_inta_sequencer
   import pic_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_IRQ-1:0]  irr,
   input  logic [NUM_IRQ-1:0]  imr,
   input  logic [NUM_IRQ-1:0]  isr_q,
   input  logic [4:0]          vec_base,
   input  logic                aeoi_mode,
   input  logic                rotate_aeoi,
   input  logic                eoi_valid,
   input  logic                eoi_specific,
   input  logic                eoi_rotate,
   input  logic [IDX_W-1:0]    eoi_level,
   input  logic                setprio_valid,
   input  logic [IDX_W-1:0]    setprio_level,
   output logic [NUM_IRQ-1:0]  isr_set,
   output logic [NUM_IRQ-1:0]  isr_clr,
   output logic [NUM_IRQ-1:0]  irr_clr,
   output logic [IDX_W-1:0]    lowest_prio,
   pic_inta_sequencer_if.slave cpu
);

   state_e               state_q, state_d;
   logic                 inta_q;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 spur_q, spur_d;
   logic                 int_out_q, int_out_d;
   logic [NUM_IRQ-1:0]   isr_set_q, isr_set_d;
   logic [NUM_IRQ-1:0]   isr_clr_q, isr_clr_d;
   logic [NUM_IRQ-1:0]   irr_clr_q, irr_clr_d;
   logic [7:0]           vec_out_q, vec_out_d;
   logic                 vec_oe_q, vec_oe_d;
   logic [IDX_W-1:0]     lowest_q, lowest_d;

   logic                 fall, rise;
   logic                 cand_found, isr_found, req_valid;
   logic [IDX_W-1:0]     cand_idx, isr_idx;
   logic [NUM_IRQ-1:0]   aeoi_clr, eoi_clr;
   logic                 aeoi_rot, eoi_rot;
   logic [IDX_W-1:0]     eoi_rot_lvl;

   assign fall = inta_q & ~cpu.inta_n;
   assign rise = ~inta_q & cpu.inta_n;

   pic_prio_resolver u_cand_res (
      .vec    (irr & ~imr),
      .lowest (lowest_q),
      .found  (cand_found),
      .idx    (cand_idx)
   );

   pic_prio_resolver u_isr_res (
      .vec    (isr_q),
      .lowest (lowest_q),
      .found  (isr_found),
      .idx    (isr_idx)
   );

   // Fully nested: the winner must outrank every level already in service.
   assign req_valid = cand_found &&
                      (!isr_found || (rank(cand_idx, lowest_q) < rank(isr_idx, lowest_q)));

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (fall) state_d = ST_ACK1;
         ST_ACK1: if (rise) state_d = ST_GAP;
         ST_GAP:  if (fall) state_d = ST_ACK2;
         ST_ACK2: if (rise) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      int_out_d = 1'b0;
      isr_set_d = '0;
      irr_clr_d = '0;
      idx_d     = idx_q;
      spur_d    = spur_q;
      vec_out_d = vec_out_q;
      vec_oe_d  = vec_oe_q;
      aeoi_clr  = '0;
      aeoi_rot  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fall) begin
               idx_d  = req_valid ? cand_idx : '1;
               spur_d = !req_valid;
               if (req_valid) begin
                  isr_set_d = onehot(cand_idx);
                  irr_clr_d = onehot(cand_idx);
               end
            end else begin
               int_out_d = req_valid;
            end
         end
         ST_GAP: begin
            if (fall) begin
               vec_out_d = {vec_base, idx_q};
               vec_oe_d  = 1'b1;
            end
         end
         ST_ACK2: begin
            if (rise) begin
               vec_oe_d = 1'b0;
               if (aeoi_mode && !spur_q) begin
                  aeoi_clr = onehot(idx_q);
                  aeoi_rot = rotate_aeoi;
               end
            end
         end
         default: ;
      endcase
   end

   // Command path: EOI clears merge with AEOI, a same-cycle set wins its bit,
   // and set-priority outranks EOI rotation, which outranks AEOI rotation.
   always_comb begin
      eoi_clr     = '0;
      eoi_rot     = 1'b0;
      eoi_rot_lvl = eoi_level;
      if (eoi_valid) begin
         if (eoi_specific) begin
            eoi_clr = onehot(eoi_level);
            eoi_rot = eoi_rotate;
         end else if (isr_found) begin
            eoi_clr     = onehot(isr_idx);
            eoi_rot     = eoi_rotate;
            eoi_rot_lvl = isr_idx;
         end
      end
      isr_clr_d = (eoi_clr | aeoi_clr) & ~isr_set_d;
      lowest_d  = lowest_q;
      if (setprio_valid)  lowest_d = setprio_level;
      else if (eoi_rot)   lowest_d = eoi_rot_lvl;
      else if (aeoi_rot)  lowest_d = idx_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inta_q    <= 1'b1;
         idx_q     <= '1;
         spur_q    <= 1'b0;
         int_out_q <= 1'b0;
         isr_set_q <= '0;
         isr_clr_q <= '0;
         irr_clr_q <= '0;
         vec_out_q <= '0;
         vec_oe_q  <= 1'b0;
         lowest_q  <= 3'd7;
      end else begin
         inta_q    <= cpu.inta_n;
         idx_q     <= idx_d;
         spur_q    <= spur_d;
         int_out_q <= int_out_d;
         isr_set_q <= isr_set_d;
         isr_clr_q <= isr_clr_d;
         irr_clr_q <= irr_clr_d;
         vec_out_q <= vec_out_d;
         vec_oe_q  <= vec_oe_d;
         lowest_q  <= lowest_d;
      end
   end

   assign cpu.int_out = int_out_q;
   assign cpu.vec_out = vec_out_q;
   assign cpu.vec_oe  = vec_oe_q;
   assign isr_set     = isr_set_q;
   assign isr_clr     = isr_clr_q;
   assign irr_clr     = irr_clr_q;
   assign lowest_prio = lowest_q;

endmodule

// File: doc/pic_inta_sequencer.md
Name: pic_inta_sequencer

Overview:
Clocked interrupt controller core for the 8259 PIC. It resolves pending requests against mask and in-service state using fully nested or rotating priority, and raises INT. It sequences the two-pulse INTA handshake, issuing set/clear strobes to the in-service register and driving the vector. It also executes EOI and priority-rotation commands. It sits between the IRR/IMR registers, the in-service register, the data-bus buffer and the command decoder.

Parameters:
NUM_IRQ, 8, number of request lines; only 8 supported, kept for readability.
IDX_W, 3, width of an IRQ index.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
irr  in  8  pending requests from the request register.
imr  in  8  mask; 1 = masked.
isr_q  in  8  current in-service bits.
vec_base  in  5  ICW2 T7..T3.
aeoi_mode  in  1  1 = automatic EOI at end of second INTA.
rotate_aeoi  in  1  rotate priority on AEOI.
eoi_valid  in  1  one-cycle EOI command strobe.
eoi_specific  in  1  1 = specific EOI, 0 = non-specific.
eoi_rotate  in  1  rotate on this EOI.
eoi_level  in  3  target level for a specific EOI.
setprio_valid  in  1  one-cycle set-priority command.
setprio_level  in  3  new lowest-priority level.
inta_n  in  1  interrupt acknowledge, active low, already synchronous to clk.
int_out  out  1  interrupt request to CPU.
isr_set  out  8  one-hot, one-cycle set strobe to the in-service register.
isr_clr  out  8  one-cycle clear strobe to the in-service register; may be multi-bit only on collision rules below.
irr_clr  out  8  one-hot, one-cycle clear of an edge-latched request.
vec_out  out  8  vector byte {vec_base, idx}.
vec_oe  out  1  vector drive enable.
lowest_prio  out  3  current lowest-priority level.

Behaviour:
- Reset values: int_out=0, isr_set=0, isr_clr=0, irr_clr=0, vec_out=0, vec_oe=0, lowest_prio=7 (IR0 highest), state=IDLE, inta_q=1.
- Priority: rank(i) = (i - lowest_prio - 1) mod 8; rank 0 is highest.
- Candidates: cand = irr & ~imr. The winner is the highest-ranked candidate.
- A request is valid when the winner ranks strictly higher than the highest-ranked bit of isr_q, or when isr_q = 0.
- Edge detection: inta_q is inta_n registered. fall = inta_q & ~inta_n. rise = ~inta_q & inta_n.
- All outputs are registered; an event detected in cycle N is visible in cycle N+1.
- FSM states: IDLE, ACK1, GAP, ACK2.
- IDLE:
  - int_out is registered from the request-valid condition.
  - On fall: latch idx = current winner. If valid, pulse isr_set[idx] and irr_clr[idx] and set spur=0; otherwise set idx=7, spur=1 and pulse no strobes.
  - In both cases clear int_out and go to ACK1.
- ACK1: on rise go to GAP.
- GAP: on fall go to ACK2. vec_out = {vec_base, idx} and vec_oe=1 from the next cycle.
- ACK2: vec_oe stays 1 while inta_n is low. On rise: clear vec_oe, return to IDLE, and run the AEOI step below.
- AEOI step: applies only if aeoi_mode=1 and spur=0. Pulse isr_clr[idx]. If rotate_aeoi=1, load lowest_prio with idx.
- int_out is re-evaluated only in IDLE. It is never asserted during ACK1, GAP or ACK2.
- Non-specific EOI (eoi_valid, eoi_specific=0): clear the highest-ranked set bit of isr_q. If isr_q=0, do nothing. If eoi_rotate=1, load lowest_prio with the cleared level.
- Specific EOI: clear isr_clr[eoi_level], even if that isr_q bit is already 0. If eoi_rotate=1, load lowest_prio with eoi_level.
- EOI and set-priority commands are accepted in any FSM state.
- setprio_valid loads lowest_prio with setprio_level. It wins over any EOI or AEOI rotation in the same cycle.
- Collision, same bit: if isr_set and isr_clr target the same bit in one cycle, the set wins and that clr bit is masked.
- Collision, different bits: EOI clear and AEOI clear in the same cycle on different bits are OR-ed into isr_clr. The EOI rotation wins over the AEOI rotation.
- Reset mid-handshake: FSM returns to IDLE, all strobes drop, and the sequence is abandoned.

Decomposition:
- Package pic_pkg: state enum, IDX_W, NUM_IRQ, function rank(idx, lowest).
- Sub-module pic_prio_resolver: combinational rotating priority encoder (8-bit vector + lowest_prio -> found, idx). Instantiated twice: once for candidates, once for isr_q (nesting check and non-specific EOI).

Test Plan:
- Single IRQ: reset, vec_base=5'h08, irr=8'h08, imr=0 -> int_out=1 after 1 cycle. First INTA gives isr_set=8'h08 and irr_clr=8'h08 for one cycle. Second INTA gives vec_out=8'h43, vec_oe=1.
- Nesting: isr_q=8'h04, irr=8'h10 -> int_out stays 0. Raise irr=8'h11 -> int_out=1 and the sequence services IR0.
- Spurious: int_out=1, then drop irr to 0 before the first INTA -> no isr_set, vec_out={base,3'd7}, no isr_clr after the second INTA.
- AEOI with rotation: aeoi_mode=1, rotate_aeoi=1, IR2 serviced -> on the second rise isr_clr=8'h04 and lowest_prio=2. Next arbitration with irr=8'h0C picks IR3.
- EOI: isr_q=8'h28, lowest_prio=7, non-specific EOI -> isr_clr=8'h08. Specific EOI with level 5 and rotate -> isr_clr=8'h20, lowest_prio=5.
- Collision/reset: setprio(3) together with a rotating EOI on level 6 -> lowest_prio=3. Asserting rst during GAP -> state IDLE, vec_oe=0, all strobes 0 next cycle.
